vga_rect_fill: RTL
==================

Name: vga_rect_fill

Overview:
- AXI4-Lite write-only manager that fills an axis-aligned rectangle of the VGA frame buffer with one RGB332 colour.
- Sits directly upstream of the vga frame buffer and drives its AXI subordinate port, through the interconnect or point-to-point.
- The CPU, or a control register block, supplies the coordinates and a start pulse.
- The block emits one word-aligned write per 32-bit word touched, with byte strobes, so pixels outside the rectangle are never modified.

Parameters:
- PIXEL_WIDTH, 640, visible pixels per row; frame buffer row stride in bytes.
- PIXEL_HEIGHT, 480, visible rows.
- PIXEL_DEPTH, 8, bits per pixel. Only 8 (RGB332, one byte per pixel) is supported.
- AXI_DATA_WIDTH, 32, AXI data width. Only 32 is supported; 4 pixels per word.

Ports:
- pxclk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  single-cycle request; sampled only in IDLE.
- x0  input  $clog2(PIXEL_WIDTH)  left column, inclusive.
- y0  input  $clog2(PIXEL_HEIGHT)  top row, inclusive.
- x1  input  $clog2(PIXEL_WIDTH)  right column, inclusive.
- y1  input  $clog2(PIXEL_HEIGHT)  bottom row, inclusive.
- color  input  PIXEL_DEPTH  fill colour.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at completion.
- err  output  1  valid with done; held until the next accepted start.
- axi  interface  axi4_lite.manager  write channels used; read channels idle (arvalid=0, rready=0).

Behaviour:
- Reset values: busy=0, done=0, err=0, awvalid=0, wvalid=0, bready=0, arvalid=0, rready=0; FSM in IDLE.
- Reset asserted mid-operation aborts immediately: all valids drop next cycle and no done pulse is produced.
- Start capture: on start in IDLE, latch x0, y0, x1, y1 and color.
- Illegal request (x1<x0, y1<y0, x1>=PIXEL_WIDTH or y1>=PIXEL_HEIGHT):
  - go to FINISH with err=1; no AXI traffic.
- Legal request: enter ISSUE with row=y0 and word=x0>>2.
- Byte address: row*PIXEL_WIDTH + 4*word, zero-extended to the interface address width.
- wdata: {4{color}}.
- wstrb bit i is set iff x0 <= 4*word+i <= x1.
- ISSUE:
  - Assert awvalid and wvalid together.
  - Each valid deasserts independently on its own handshake; awaddr/wdata/wstrb are held stable while their valid is high.
  - When both handshakes have completed (same or different cycles), go to RESP.
- RESP:
  - bready=1.
  - On bvalid with bresp != OKAY: err=1, go to FINISH; the remaining words are not written.
  - On bvalid with OKAY: go to NEXT.
- NEXT:
  - If word < x1>>2: word+1.
  - Else if row < y1: row+1, word = x0>>2.
  - Else go to FINISH.
  - Otherwise return to ISSUE. One outstanding transaction at most.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- start while busy: ignored and not queued.
- start in the same cycle as the done pulse: ignored.
- Latency:
  - First awvalid appears 2 cycles after start.
  - With a zero-wait subordinate, each word takes 4 cycles (ISSUE, handshake, RESP, NEXT).
- Word count per row: (x1>>2) - (x0>>2) + 1. Full screen = 160 x 480 = 76800 writes.
- Address arithmetic: row*PIXEL_WIDTH is computed by a per-row accumulator (add PIXEL_WIDTH on each row advance). No multiplier.

Test Plan:
- Single pixel, x0=x1=5, y0=y1=2, color=8'hE0 -> exactly one write: awaddr=1284, wdata=32'hE0E0E0E0, wstrb=4'b0010; done after bresp; err=0.
- Word-straddling span, x0=3, x1=9, y0=y1=0 -> three writes:
  - addr 0, strb 4'b1000
  - addr 4, strb 4'b1111
  - addr 8, strb 4'b0011
- Multi-row, x0=0, x1=7, y0=10, y1=11 -> addresses 6400, 6404, 7040, 7044, all strb 4'b1111, in that order.
- Illegal inputs:
  - x1=2, x0=4 -> done with err=1 and zero awvalid cycles.
  - y1=480 -> done with err=1 and zero awvalid cycles.
- Backpressure: random awready/wready/bvalid stalls including aw-before-w and w-before-aw -> every word written once, with payload stable while valid; with bresp=SLVERR on the 2nd word -> done with err=1 after exactly 2 writes.
- Full screen fill, 0..639 x 0..479, color=8'h1C -> frame buffer model all 8'h1C, 76800 writes; start pulses while busy ignored; rst_n low mid-fill drops valids and busy next cycle.

Source files
------------

// File: rtl/vga_rect_fill.sv
// rtl/vga_rect_fill.sv - AXI4-Lite write manager that fills a frame-buffer rectangle with one colour
module vga_rect_fill #(
    parameter int PIXEL_WIDTH    = 640,
    parameter int PIXEL_HEIGHT   = 480,
    parameter int PIXEL_DEPTH    = 8,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    localparam int XW = $clog2(PIXEL_WIDTH),
    localparam int YW = $clog2(PIXEL_HEIGHT)
) (
    input  logic                          pxclk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [XW-1:0]                 x0,
    input  logic [YW-1:0]                 y0,
    input  logic [XW-1:0]                 x1,
    input  logic [YW-1:0]                 y1,
    input  logic [PIXEL_DEPTH-1:0]        color,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [AXI_ADDR_WIDTH-1:0]     awaddr,
    output logic [2:0]                    awprot,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [AXI_DATA_WIDTH-1:0]     wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    output logic [AXI_ADDR_WIDTH-1:0]     araddr,
    output logic [2:0]                    arprot,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [AXI_DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int AW  = AXI_ADDR_WIDTH;
    localparam int WW  = XW - 2;
    localparam int BPW = AXI_DATA_WIDTH / PIXEL_DEPTH;
    localparam logic [XW:0] X_LIM = (XW+1)'(PIXEL_WIDTH);
    localparam logic [YW:0] Y_LIM = (YW+1)'(PIXEL_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_RESP,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [XW-1:0]          x0_q, x1_q;
    logic [YW-1:0]          row_q, y1_q;
    logic [WW-1:0]          word_q;
    logic [AW-1:0]          row_base_q;
    logic [PIXEL_DEPTH-1:0] color_q;
    logic                   awvalid_q, wvalid_q, err_q;

    logic                   req_illegal;
    logic                   aw_clear, w_clear, last_word, bresp_bad;
    logic [AW-1:0]          start_base;
    logic [XW:0]            col;
    logic [BPW-1:0]         strb_c;
    logic                   unused_rd;

    assign req_illegal = (x1 < x0) || (y1 < y0) ||
                         ({1'b0, x1} >= X_LIM) || ({1'b0, y1} >= Y_LIM);

    // y0*PIXEL_WIDTH as a sum of shifted copies over the constant's set bits
    always_comb begin
        start_base = '0;
        for (int b = 0; b <= XW; b++) begin
            if (X_LIM[b]) start_base = start_base + (AW'(y0) << b);
        end
    end

    assign aw_clear  = !awvalid_q || awready;
    assign w_clear   = !wvalid_q || wready;
    assign bresp_bad = (bresp != 2'b00);
    assign last_word = (word_q == x1_q[XW-1:2]) && (row_q == y1_q);

    always_ff @(posedge pxclk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = req_illegal ? S_FINISH : S_ISSUE;
            S_ISSUE:  state_nxt = S_XFER;
            S_XFER:   if (aw_clear && w_clear) state_nxt = S_RESP;
            S_RESP:   if (bvalid) state_nxt = bresp_bad ? S_FINISH : S_NEXT;
            S_NEXT:   state_nxt = last_word ? S_FINISH : S_ISSUE;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            row_q      <= '0;
            word_q     <= '0;
            row_base_q <= '0;
            color_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x0_q       <= x0;
                        x1_q       <= x1;
                        y1_q       <= y1;
                        row_q      <= y0;
                        word_q     <= x0[XW-1:2];
                        row_base_q <= start_base;
                        color_q    <= color;
                        err_q      <= req_illegal;
                    end
                end
                S_ISSUE: begin
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                end
                S_XFER: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                end
                S_RESP: begin
                    if (bvalid && bresp_bad) err_q <= 1'b1;
                end
                S_NEXT: begin
                    if (word_q != x1_q[XW-1:2]) begin
                        word_q <= word_q + 1'b1;
                    end else if (row_q != y1_q) begin
                        row_q      <= row_q + 1'b1;
                        word_q     <= x0_q[XW-1:2];
                        row_base_q <= row_base_q + AW'(PIXEL_WIDTH);
                    end
                end
                default: ;
            endcase
        end
    end

    // a byte lane is written only when its column lies inside [x0, x1]
    always_comb begin
        strb_c = '0;
        col    = '0;
        for (int i = 0; i < BPW; i++) begin
            col       = {1'b0, word_q, 2'b00} + (XW+1)'(i);
            strb_c[i] = (col >= {1'b0, x0_q}) && (col <= {1'b0, x1_q});
        end
    end

    assign busy    = (state == S_ISSUE) || (state == S_XFER) ||
                     (state == S_RESP)  || (state == S_NEXT);
    assign done    = (state == S_FINISH);
    assign err     = err_q;

    assign awaddr  = row_base_q + AW'({word_q, 2'b00});
    assign awprot  = 3'b000;
    assign awvalid = awvalid_q;
    assign wdata   = {BPW{color_q}};
    assign wstrb   = strb_c;
    assign wvalid  = wvalid_q;
    assign bready  = (state == S_RESP);

    assign araddr  = '0;
    assign arprot  = 3'b000;
    assign arvalid = 1'b0;
    assign rready  = 1'b0;

    assign unused_rd = ^{arready, rdata, rresp, rvalid};

endmodule
